// File: rtl/key_event_scheduler.sv
// Per-key press / auto-repeat / release event scheduler.
// Pending events of all keys are serialized by a round-robin arbiter onto a valid/ready command port.
module key_event_scheduler #(
    parameter int                  NUM_KEYS     = 4,
    parameter int                  REPEAT_DELAY = 12,
    parameter int                  REPEAT_RATE  = 3,
    parameter logic [NUM_KEYS-1:0] REPEAT_MASK  = 4'b0011
) (
    input  logic                        clk,
    input  logic                        resetN,
    input  logic                        startOfFrame,
    input  logic [NUM_KEYS-1:0]         key_rise,
    input  logic [NUM_KEYS-1:0]         key_pressed,
    input  logic                        cmd_ready,
    output logic                        cmd_valid,
    output logic [$clog2(NUM_KEYS)-1:0] cmd_key,
    output logic [1:0]                  cmd_type,
    output logic                        overflow
);

    localparam int         KW        = $clog2(NUM_KEYS);
    localparam logic [7:0] DELAY_F   = 8'(REPEAT_DELAY);
    localparam logic [7:0] RATE_F    = 8'(REPEAT_RATE);
    localparam logic [1:0] T_PRESS   = 2'b00;
    localparam logic [1:0] T_REPEAT  = 2'b01;
    localparam logic [1:0] T_RELEASE = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } key_state_e;

    // Key index 'offset' positions after 'base', wrapping at NUM_KEYS.
    function automatic logic [KW-1:0] rr_index(input logic [KW-1:0] base, input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= NUM_KEYS) begin
            sum = sum - NUM_KEYS;
        end
        return KW'(sum);
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    key_state_e          state_q [NUM_KEYS];
    key_state_e          state_d [NUM_KEYS];
    logic [7:0]          cnt_q   [NUM_KEYS];
    logic [7:0]          cnt_d   [NUM_KEYS];
    logic [NUM_KEYS-1:0] first_q, first_d;
    logic [NUM_KEYS-1:0] press_q, press_d;
    logic [NUM_KEYS-1:0] rel_q, rel_d;
    logic [NUM_KEYS-1:0] rep_q, rep_d;
    logic [NUM_KEYS-1:0] press_set, rel_set, rep_set;
    logic [NUM_KEYS-1:0] clr_press, clr_rel, clr_rep;
    logic [NUM_KEYS-1:0] pend_any;
    logic [KW-1:0]       ptr_q, ptr_d;
    logic                grant;
    logic [KW-1:0]       gnt_key;
    logic [1:0]          gnt_type;
    logic                cmd_valid_q, cmd_valid_d;
    logic [KW-1:0]       cmd_key_q, cmd_key_d;
    logic [1:0]          cmd_type_q, cmd_type_d;
    logic                ovf_q, ovf_d;

    assign pend_any = press_q | rel_q | rep_q;

    // Round-robin search starting at the pointer; lowest offset wins.
    always_comb begin
        grant   = 1'b0;
        gnt_key = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (!cmd_valid_q && pend_any[rr_index(ptr_q, i)]) begin
                grant   = 1'b1;
                gnt_key = rr_index(ptr_q, i);
            end
        end
    end

    always_comb begin
        gnt_type  = T_PRESS;
        clr_press = '0;
        clr_rel   = '0;
        clr_rep   = '0;
        if (grant) begin
            if (press_q[gnt_key]) begin
                gnt_type           = T_PRESS;
                clr_press[gnt_key] = 1'b1;
            end else if (rel_q[gnt_key]) begin
                gnt_type         = T_RELEASE;
                clr_rel[gnt_key] = 1'b1;
            end else begin
                gnt_type         = T_REPEAT;
                clr_rep[gnt_key] = 1'b1;
            end
        end
    end

    // Per-key FSM and frame counter next-state.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        first_d   = first_q;
        press_set = '0;
        rel_set   = '0;
        rep_set   = '0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            case (state_q[k])
                IDLE: begin
                    if (key_rise[k]) begin
                        state_d[k]   = HELD;
                        press_set[k] = 1'b1;
                        cnt_d[k]     = '0;
                        first_d[k]   = 1'b0;
                    end
                end
                HELD: begin
                    if (!key_pressed[k]) begin
                        state_d[k] = IDLE;
                        rel_set[k] = 1'b1;
                    end else if (REPEAT_MASK[k] && startOfFrame) begin
                        if (sat_inc(cnt_q[k]) == (first_q[k] ? RATE_F : DELAY_F)) begin
                            rep_set[k] = 1'b1;
                            cnt_d[k]   = '0;
                            first_d[k] = 1'b1;
                        end else begin
                            cnt_d[k] = sat_inc(cnt_q[k]);
                        end
                    end
                end
                default: state_d[k] = IDLE;
            endcase
        end
    end

    // A grant clear and a new event on the same bit leave the bit set; only
    // an event hitting a bit that stays pending counts as coalesced.
    always_comb begin
        press_d = (press_q & ~clr_press) | press_set;
        rel_d   = (rel_q & ~clr_rel) | rel_set;
        rep_d   = ((rep_q & ~clr_rep) | rep_set) & ~rel_set;
        ovf_d   = |((press_set & press_q & ~clr_press) |
                    (rel_set & rel_q & ~clr_rel) |
                    (rep_set & rep_q & ~clr_rep));
    end

    always_comb begin
        cmd_valid_d = cmd_valid_q;
        cmd_key_d   = cmd_key_q;
        cmd_type_d  = cmd_type_q;
        ptr_d       = ptr_q;
        if (cmd_valid_q) begin
            if (cmd_ready) begin
                cmd_valid_d = 1'b0;
            end
        end else if (grant) begin
            cmd_valid_d = 1'b1;
            cmd_key_d   = gnt_key;
            cmd_type_d  = gnt_type;
            ptr_d       = rr_index(gnt_key, 1);
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                state_q[k] <= IDLE;
                cnt_q[k]   <= '0;
            end
            first_q     <= '0;
            press_q     <= '0;
            rel_q       <= '0;
            rep_q       <= '0;
            ptr_q       <= '0;
            cmd_valid_q <= 1'b0;
            cmd_key_q   <= '0;
            cmd_type_q  <= T_PRESS;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            first_q     <= first_d;
            press_q     <= press_d;
            rel_q       <= rel_d;
            rep_q       <= rep_d;
            ptr_q       <= ptr_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_key_q   <= cmd_key_d;
            cmd_type_q  <= cmd_type_d;
            ovf_q       <= ovf_d;
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_key   = cmd_key_q;
    assign cmd_type  = cmd_type_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_key_event_scheduler.sv
// Bench for key_event_scheduler: event-level reference model compared every cycle,
// plus hand-computed cycle/value expectations for the directed scenarios.
module tb_key_event_scheduler;

    localparam int         NK   = 4;
    localparam int         DLY  = 12;
    localparam int         RATE = 3;
    localparam logic [3:0] MASK = 4'b0011;

    logic       clk          = 1'b0;
    logic       resetN       = 1'b0;
    logic       startOfFrame = 1'b0;
    logic [3:0] key_rise     = '0;
    logic [3:0] key_pressed  = '0;
    logic       cmd_ready    = 1'b1;
    logic       cmd_valid;
    logic [1:0] cmd_key;
    logic [1:0] cmd_type;
    logic       overflow;

    key_event_scheduler #(
        .NUM_KEYS    (NK),
        .REPEAT_DELAY(DLY),
        .REPEAT_RATE (RATE),
        .REPEAT_MASK (MASK)
    ) dut (
        .clk         (clk),
        .resetN      (resetN),
        .startOfFrame(startOfFrame),
        .key_rise    (key_rise),
        .key_pressed (key_pressed),
        .cmd_ready   (cmd_ready),
        .cmd_valid   (cmd_valid),
        .cmd_key     (cmd_key),
        .cmd_type    (cmd_type),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model (event level) ----------------
    bit m_held [NK];
    bit m_pp   [NK];
    bit m_pr   [NK];
    bit m_prep [NK];
    int m_fh   [NK];
    bit m_v;
    int m_k;
    int m_t;
    int m_ptr;
    bit m_ovf;

    task automatic m_reset();
        for (int k = 0; k < NK; k++) begin
            m_held[k] = 0; m_pp[k] = 0; m_pr[k] = 0; m_prep[k] = 0; m_fh[k] = 0;
        end
        m_v = 0; m_k = 0; m_t = 0; m_ptr = 0; m_ovf = 0;
    endtask

    task automatic m_step();
        int g;
        g = -1;
        if (!m_v) begin
            for (int j = 0; j < NK; j++) begin
                int k;
                k = (m_ptr + j) % NK;
                if (g < 0 && (m_pp[k] || m_pr[k] || m_prep[k])) g = k;
            end
        end
        if (m_v) begin
            if (cmd_ready) m_v = 0;
        end else if (g >= 0) begin
            m_v = 1;
            m_k = g;
            if (m_pp[g]) begin m_t = 0; m_pp[g] = 0; end
            else if (m_pr[g]) begin m_t = 2; m_pr[g] = 0; end
            else begin m_t = 1; m_prep[g] = 0; end
            m_ptr = (g + 1) % NK;
        end
        m_ovf = 0;
        for (int k = 0; k < NK; k++) begin
            bit evp, evr, evq;
            evp = 0; evr = 0; evq = 0;
            if (!m_held[k]) begin
                if (key_rise[k]) begin evp = 1; m_held[k] = 1; m_fh[k] = 0; end
            end else if (!key_pressed[k]) begin
                evr = 1; m_held[k] = 0;
            end else if (MASK[k] && startOfFrame) begin
                m_fh[k]++;
                if (m_fh[k] >= DLY && ((m_fh[k] - DLY) % RATE) == 0) evq = 1;
            end
            if (evp) begin if (m_pp[k]) m_ovf = 1; m_pp[k] = 1; end
            if (evr) begin if (m_pr[k]) m_ovf = 1; m_pr[k] = 1; m_prep[k] = 0; end
            if (evq) begin if (m_prep[k]) m_ovf = 1; m_prep[k] = 1; end
        end
    endtask

    initial begin : model
        m_reset();
        forever begin
            @(posedge clk or negedge resetN);
            if (!resetN) m_reset();
            else m_step();
        end
    end

    // ---------------- compare process ----------------
    typedef struct {
        int cyc;
        int kind;   // 0: cmd (val=valid), 1: overflow, 2: accepted-command tally
        int key;
        int typ;
        int val;
    } lit_t;
    lit_t lits[$];

    int n_checks = 0;
    int n_fail   = 0;
    int tally [NK][4];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    initial begin : compare
        int li;
        li = 0;
        for (int k = 0; k < NK; k++) for (int t = 0; t < 4; t++) tally[k][t] = 0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("model_valid", 8'(cmd_valid), 8'(m_v));
            chk("model_key", 8'(cmd_key), 8'(m_k));
            chk("model_type", 8'(cmd_type), 8'(m_t));
            chk("model_overflow", 8'(overflow), 8'(m_ovf));
            while (li < lits.size() && lits[li].cyc <= cyc) begin
                if (lits[li].cyc < cyc) begin
                    chk("lit_late", 8'(lits[li].cyc), 8'(cyc));
                end else if (lits[li].kind == 0) begin
                    chk("lit_valid", 8'(cmd_valid), 8'(lits[li].val));
                    chk("lit_key", 8'(cmd_key), 8'(lits[li].key));
                    chk("lit_type", 8'(cmd_type), 8'(lits[li].typ));
                end else if (lits[li].kind == 1) begin
                    chk("lit_overflow", 8'(overflow), 8'(lits[li].val));
                end else begin
                    chk("lit_tally", 8'(tally[lits[li].key][lits[li].typ]), 8'(lits[li].val));
                end
                li++;
            end
            if (resetN && cmd_valid && cmd_ready) tally[cmd_key][cmd_type]++;
            if (!resetN) begin
                for (int k = 0; k < NK; k++) for (int t = 0; t < 4; t++) tally[k][t] = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic add_lit(input int dc, input int kind, input int key, input int typ, input int val);
        lit_t e;
        e.cyc = cyc + dc; e.kind = kind; e.key = key; e.typ = typ; e.val = val;
        lits.push_back(e);
    endtask

    task automatic step(input logic [3:0] r, input logic [3:0] p, input logic s, input logic rd);
        @(posedge clk);
        #1;
        key_rise     = r;
        key_pressed  = p;
        startOfFrame = s;
        cmd_ready    = rd;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        resetN       = 1'b0;
        key_rise     = '0;
        key_pressed  = '0;
        startOfFrame = 1'b0;
        cmd_ready    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        resetN = 1'b1;
    endtask

    initial begin : main
        logic [3:0] pr;
        logic [3:0] r;

        @(posedge clk);
        #1;
        add_lit(0, 0, 0, 0, 0);
        add_lit(0, 1, 0, 0, 0);
        @(posedge clk);
        #1;
        resetN = 1'b1;

        // single key press then release
        step(4'b0100, 4'b0100, 0, 1);
        add_lit(2, 0, 2, 0, 1);
        add_lit(3, 0, 2, 0, 0);
        repeat (4) step(0, 4'b0100, 0, 1);
        step(0, 0, 0, 1);
        add_lit(2, 0, 2, 2, 1);
        add_lit(3, 0, 2, 2, 0);
        repeat (6) step(0, 0, 0, 1);
        add_lit(0, 2, 2, 0, 1);
        add_lit(0, 2, 2, 2, 1);
        add_lit(0, 2, 2, 1, 0);
        add_lit(0, 2, 0, 0, 0);

        // simultaneous presses on keys 0,1,3
        do_reset();
        step(4'b1011, 4'b1011, 0, 1);
        add_lit(2, 0, 0, 0, 1);
        add_lit(4, 0, 1, 0, 1);
        add_lit(6, 0, 3, 0, 1);
        add_lit(7, 0, 3, 0, 0);
        repeat (9) step(0, 4'b1011, 0, 1);
        step(0, 0, 0, 1);
        add_lit(2, 0, 0, 2, 1);
        add_lit(4, 0, 1, 2, 1);
        add_lit(6, 0, 3, 2, 1);
        repeat (8) step(0, 0, 0, 1);

        // key 0 auto-repeat over 20 frames
        do_reset();
        step(4'b0001, 4'b0001, 0, 1);
        add_lit(2, 0, 0, 0, 1);
        for (int f = 1; f <= 20; f++) begin
            repeat (3) step(0, 4'b0001, 0, 1);
            step(0, 4'b0001, 1, 1);
            if (f == 11) add_lit(2, 0, 0, 0, 0);
            if (f == 12 || f == 15 || f == 18) add_lit(2, 0, 0, 1, 1);
        end
        repeat (2) step(0, 4'b0001, 0, 1);
        step(0, 0, 0, 1);
        add_lit(2, 0, 0, 2, 1);
        repeat (4) step(0, 0, 0, 1);
        add_lit(0, 2, 0, 1, 3);
        add_lit(0, 2, 0, 0, 1);
        add_lit(0, 2, 0, 2, 1);

        // key 2 without repeat held 30 frames
        do_reset();
        step(4'b0100, 4'b0100, 0, 1);
        for (int f = 1; f <= 30; f++) begin
            step(0, 4'b0100, 0, 1);
            step(0, 4'b0100, 1, 1);
        end
        step(0, 0, 0, 1);
        repeat (4) step(0, 0, 0, 1);
        add_lit(0, 2, 2, 0, 1);
        add_lit(0, 2, 2, 1, 0);
        add_lit(0, 2, 2, 2, 1);

        // consumer stalled while key 0 repeats, then drained
        do_reset();
        step(4'b0001, 4'b0001, 0, 0);
        add_lit(2, 0, 0, 0, 1);
        for (int f = 1; f <= 40; f++) begin
            repeat (3) step(0, 4'b0001, 0, 0);
            step(0, 4'b0001, 1, 0);
            if (f == 12) add_lit(1, 1, 0, 0, 0);
            if (f == 15) begin add_lit(1, 1, 0, 0, 1); add_lit(2, 1, 0, 0, 0); end
            if (f == 20) add_lit(0, 0, 0, 0, 1);
        end
        step(0, 4'b0001, 0, 1);
        add_lit(1, 0, 0, 0, 0);
        add_lit(2, 0, 0, 1, 1);
        add_lit(3, 0, 0, 1, 0);
        repeat (5) step(0, 4'b0001, 0, 1);
        add_lit(0, 2, 0, 0, 1);
        add_lit(0, 2, 0, 1, 1);
        step(0, 0, 0, 1);
        repeat (4) step(0, 0, 0, 1);

        // asynchronous reset with a command showing and three events queued
        do_reset();
        step(4'b1110, 4'b1110, 0, 0);
        add_lit(2, 0, 1, 0, 1);
        repeat (2) step(0, 4'b1110, 0, 0);
        step(0, 4'b0110, 0, 0);
        repeat (2) step(0, 4'b0110, 0, 0);
        add_lit(0, 0, 1, 0, 1);
        @(posedge clk);
        #1;
        resetN = 1'b0;
        cmd_ready = 1'b1;
        add_lit(0, 0, 0, 0, 0);
        add_lit(0, 1, 0, 0, 0);
        repeat (2) step(0, 4'b0110, 0, 1);
        @(posedge clk);
        #1;
        resetN = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(0, 4'b0110, 0, 1);
            if (i == 2 || i == 9) add_lit(0, 0, 0, 0, 0);
        end
        step(4'b0010, 4'b0110, 0, 1);
        add_lit(2, 0, 1, 0, 1);
        repeat (3) step(0, 4'b0110, 0, 1);
        step(0, 0, 0, 1);
        repeat (4) step(0, 0, 0, 1);

        // randomized traffic against the model
        do_reset();
        pr = '0;
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < NK; k++) begin
                r[k] = ($urandom_range(0, 7) == 0);
                if ($urandom_range(0, 9) == 0) pr[k] = ~pr[k];
            end
            step(r, pr, ($urandom_range(0, 5) == 0),
                 (i < 1500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0));
            if (i == 2000) do_reset();
        end
        repeat (4) step(0, 0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/key_event_scheduler.md
# key_event_scheduler

Per-key event scheduler for the keyboard subsystem. Takes per-key make pulses and held levels from the keyboard decoder and turns them into a serialized stream of press, auto-repeat and release commands. The stream is delivered one command at a time over a valid/ready handshake to the game control logic. Keys with simultaneous events are served by a round-robin arbiter; held movement keys generate frame-paced auto-repeat.

## Interface
Parameters:
- NUM_KEYS, 4, number of tracked keys (2..8)
- REPEAT_DELAY, 12, frames from press to first repeat (1..255)
- REPEAT_RATE, 3, frames between subsequent repeats (1..255)
- REPEAT_MASK, 4'b0011, bit k=1 enables auto-repeat for key k

Ports:
- clk  in  1  system clock
- resetN  in  1  reset; asynchronous, active-low
- startOfFrame  in  1  one-cycle pulse per video frame
- key_rise  in  NUM_KEYS  one-cycle pulse per received make code, per key
- key_pressed  in  NUM_KEYS  level, 1 while key is held
- cmd_ready  in  1  consumer accepts cmd this cycle
- cmd_valid  out  1  command available
- cmd_key  out  $clog2(NUM_KEYS)  key index of command
- cmd_type  out  2  2'b00 press, 2'b01 repeat, 2'b10 release (2'b11 never driven)
- overflow  out  1  one-cycle pulse when an event coalesces with an identical pending one

## Operation
- Per-key FSM, two states:
  - IDLE: key_rise → HELD, set press_pend, clear frame counter.
  - HELD: key_rise ignored (typematic make codes); key_pressed=0 → IDLE, set rel_pend, clear rep_pend.
- Frame counter (8 bit, per key) counts startOfFrame only in HELD and only if REPEAT_MASK[k]=1.
  - Reaching REPEAT_DELAY sets rep_pend and reloads the counter to 0.
  - After the first repeat, each REPEAT_RATE frames sets rep_pend.
  - Counter saturates; it never wraps.
- Setting a pending bit that is already set: no new event, overflow pulses for 1 cycle. Simultaneous overflows from several keys produce a single pulse.
- Per-key selection order: press_pend first, then rel_pend, then rep_pend. A key with press+release both pending therefore emits press, then release.
- Arbiter: round-robin over keys with any pending bit. The pointer starts at key 0 after reset. After a grant, priority begins at granted key + 1, mod NUM_KEYS.
- Grant only when the output register is empty (cmd_valid=0).
  - On grant: load cmd_key and cmd_type, set cmd_valid, clear the selected pending bit in the same edge.
- A pending bit set in the same cycle it is cleared by a grant stays set (the new event wins).
- cmd_valid, cmd_key and cmd_type are held stable until the cycle with cmd_valid & cmd_ready. cmd_valid drops on the next edge.

## Timing
- Reset values:
  - cmd_valid=0, cmd_key=0, cmd_type=2'b00, overflow=0.
  - All FSMs IDLE, all pending bits 0, counters 0, arbiter pointer 0.
- Asynchronous reset mid-handshake discards the pending command and all queued events. No partial command survives.
- Latency:
  - key_rise at edge t → press_pend at t+1 → cmd_valid at t+2, provided the output is empty and no other key holds priority.
  - Release: key_pressed falling sampled at t → cmd_valid at t+2 under the same conditions.
- Throughput: at most one command every 2 cycles (accept cycle, then grant cycle).
- key_rise and key_pressed=0 in the same IDLE cycle: treated as press. Release is detected on the next cycle in HELD.
- startOfFrame coinciding with key release: release wins, no repeat is generated.
- Keys with REPEAT_MASK=0 never produce 2'b01.

## Test plan
- Reset, then key 2 key_rise with pressed held 5 cycles and cmd_ready=1 → (valid,key,type) = (1,2,00) at cycle 2 after rise. Release → (1,2,10) 2 cycles after pressed falls. No other commands.
- Keys 0,1,3 rise in the same cycle, cmd_ready=1 → commands in order key 0, 1, 3, each press, on cycles 2, 4, 6.
- Key 0 held (REPEAT_DELAY=12, RATE=3) for 20 frames → press at rise. Repeats after frames 12, 15 and 18: exactly 3 repeats. Then release.
- Key 2 (mask 0) held 30 frames → only press and release, no repeat.
- cmd_ready=0 for 40 frames while key 0 is held → exactly one press shown stable. overflow pulses when a second repeat coalesces. Raising cmd_ready delivers press, then a single repeat.
- Assert resetN=0 while cmd_valid=1 with 3 pending events → all outputs 0 immediately. After release of reset, no command emerges until a new key_rise.
